mem_req_ctrl: RTL and testbench

- Memory-stage request sequencer that sits directly upstream of the cache FSM wrapper.
- Accepts a single load/store request from the pipeline and registers it. Holds addr/data/read/write to the cache stable until the cache signals done.
- Stalls the pipeline while the request is outstanding, then returns load data.
- Also provides a watchdog timeout, a sticky error flag, and saturating request/hit counters for performance checks.

---
 rtl/mem_req_pkg.sv | 15 +
 rtl/sat_counter.sv | 31 +++
 rtl/mem_req_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_req_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory-stage request sequencer:
// FSM state encoding and the default parameter values.
package mem_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10,
        ERRW = 2'b11
    } state_e;

    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: clocked state is assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-stage request sequencer: registers one pipeline load/store, holds it
// to the cache FSM until done, stalls the pipeline and returns load data.
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      p_addr,
    input  logic [15:0]      p_wdata,
    input  logic             p_read,
    input  logic             p_write,
    output logic [15:0]      c_addr,
    output logic [15:0]      c_data_in,
    output logic             c_read,
    output logic             c_write,
    input  logic [15:0]      c_data_out,
    input  logic             c_done,
    input  logic             c_hit,
    input  logic             c_err,
    output logic             stall,
    output logic [15:0]      rdata,
    output logic             rdata_valid,
    output logic             err,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] c_addr_q, c_addr_d;
    logic [15:0] c_data_in_q, c_data_in_d;
    logic        c_read_q, c_read_d;
    logic        c_write_q, c_write_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  wd_q, wd_d;
    logic        req_inc, hit_inc;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        c_addr_d    = c_addr_q;
        c_data_in_d = c_data_in_q;
        c_read_d    = c_read_q;
        c_write_d   = c_write_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wd_d        = wd_q;
        stall       = 1'b0;
        req_inc     = 1'b0;
        hit_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (p_read ^ p_write) begin
                    c_addr_d    = p_addr;
                    c_data_in_d = p_wdata;
                    c_read_d    = p_read;
                    c_write_d   = p_write;
                    wd_d        = '0;
                    stall       = 1'b1;
                    state_d     = BUSY;
                end else if (p_read && p_write) begin
                    err_d   = 1'b1;
                    stall   = 1'b1;
                    state_d = ERRW;
                end
            end
            BUSY: begin
                // Strobes stay up through the done cycle so a write can finish its refill.
                stall = 1'b1;
                wd_d  = wd_q + 8'd1;
                if (c_err) begin
                    err_d = 1'b1;
                end
                if (c_done) begin
                    if (c_read_q) begin
                        rdata_d = c_data_out;
                    end
                    req_inc   = 1'b1;
                    hit_inc   = c_hit;
                    c_read_d  = 1'b0;
                    c_write_d = 1'b0;
                    state_d   = RESP;
                end else if (wd_q == WD_LAST) begin
                    err_d     = 1'b1;
                    c_read_d  = 1'b0;
                    c_write_d = 1'b0;
                    state_d   = ERRW;
                end
            end
            RESP:    state_d = IDLE;
            ERRW:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            c_addr_q    <= '0;
            c_data_in_q <= '0;
            c_read_q    <= 1'b0;
            c_write_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            c_addr_q    <= c_addr_d;
            c_data_in_q <= c_data_in_d;
            c_read_q    <= c_read_d;
            c_write_q   <= c_write_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_req_cnt (
        .clk (clk),
        .rst (rst),
        .inc (req_inc),
        .cnt (req_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .cnt (hit_cnt)
    );

    assign c_addr      = c_addr_q;
    assign c_data_in   = c_data_in_q;
    assign c_read      = c_read_q;
    assign c_write     = c_write_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == RESP);
    assign err         = err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: transaction-level reference model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_mem_req_ctrl;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_CNT_W   = 2;
    localparam int CMAX       = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [15:0]         p_addr = '0, p_wdata = '0;
    logic                p_read = 1'b0, p_write = 1'b0;
    logic [15:0]         c_data_out = '0;
    logic                c_done = 1'b0, c_hit = 1'b0, c_err = 1'b0;
    logic [15:0]         c_addr, c_data_in, rdata;
    logic                c_read, c_write, stall, rdata_valid, err;
    logic [TB_CNT_W-1:0] req_cnt, hit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_read(p_read), .p_write(p_write),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_read(c_read), .c_write(c_write),
        .c_data_out(c_data_out), .c_done(c_done), .c_hit(c_hit), .c_err(c_err),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .req_cnt(req_cnt), .hit_cnt(hit_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding request and how many cycles it has waited.
    typedef enum {PH_IDLE, PH_WAIT, PH_DONE, PH_ABORT} phase_t;
    phase_t      ph = PH_IDLE;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic        m_rd = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    int          m_waited = 0, m_req = 0, m_hit = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= PH_IDLE; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
            m_rd <= 1'b0; m_wr <= 1'b0; m_err <= 1'b0;
            m_waited <= 0; m_req <= 0; m_hit <= 0;
        end else begin
            case (ph)
                PH_IDLE: begin
                    if (p_read != p_write) begin
                        m_addr <= p_addr; m_wdata <= p_wdata;
                        m_rd <= p_read; m_wr <= p_write;
                        m_waited <= 0;
                        ph <= PH_WAIT;
                    end else if (p_read && p_write) begin
                        m_err <= 1'b1;
                        ph <= PH_ABORT;
                    end
                end
                PH_WAIT: begin
                    m_waited <= m_waited + 1;
                    if (c_err) m_err <= 1'b1;
                    if (c_done) begin
                        if (m_rd) m_rdata <= c_data_out;
                        m_req <= (m_req < CMAX) ? m_req + 1 : CMAX;
                        if (c_hit) m_hit <= (m_hit < CMAX) ? m_hit + 1 : CMAX;
                        ph <= PH_DONE;
                    end else if (m_waited + 1 == TB_TIMEOUT) begin
                        m_err <= 1'b1;
                        ph <= PH_ABORT;
                    end
                end
                default: ph <= PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("c_addr",      c_addr,      m_addr);
        check("c_data_in",   c_data_in,   m_wdata);
        check("c_read",      c_read,      (ph == PH_WAIT) && m_rd);
        check("c_write",     c_write,     (ph == PH_WAIT) && m_wr);
        check("stall",       stall,       (ph == PH_WAIT) || ((ph == PH_IDLE) && (p_read || p_write)));
        check("rdata_valid", rdata_valid, ph == PH_DONE);
        check("rdata",       rdata,       m_rdata);
        check("err",         err,         m_err);
        check("req_cnt",     req_cnt,     m_req);
        check("hit_cnt",     hit_cnt,     m_hit);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) step();
        #1 rst = 1'b0;
        step();
    endtask

    // Cycle 0 presents the request; cycle N (N>0) of the run is BUSY cycle N.
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input int done_at, input logic hit, input logic [15:0] dout,
                           input int err_at, input int ncyc,
                           output int stall_n, output int act_n, output int first_act, output int valid_at);
        stall_n = 0; act_n = 0; first_act = -1; valid_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            p_read  = (c == 0) ? rd : 1'b0;
            p_write = (c == 0) ? wr : 1'b0;
            p_addr  = a;
            p_wdata = d;
            c_done     = (done_at > 0) && (c == done_at);
            c_hit      = c_done ? hit : 1'b0;
            c_data_out = c_done ? dout : 16'hDEAD;
            c_err      = (err_at > 0) && (c == err_at);
            @(negedge clk);
            if (stall) stall_n++;
            if (c_read || c_write) begin
                act_n++;
                if (first_act < 0) first_act = c;
            end
            if (rdata_valid && valid_at < 0) valid_at = c;
            step();
        end
        p_read = 1'b0; p_write = 1'b0; c_done = 1'b0; c_hit = 1'b0; c_err = 1'b0;
    endtask

    int s_n, a_n, f_a, v_at;

    initial begin
        do_reset();
        check("reset rdata", rdata, 16'h0);
        check("reset err", err, 1'b0);
        check("reset req_cnt", req_cnt, 0);
        check("reset c_read", c_read, 1'b0);

        // Load hit, done in the 2nd BUSY cycle.
        run_req(1'b1, 1'b0, 16'h1238, 16'h0, 2, 1'b1, 16'hBEEF, 0, 4, s_n, a_n, f_a, v_at);
        check("hit stall cycles", s_n, 3);
        check("hit valid cycle", v_at, 3);
        check("hit read cycles", a_n, 2);
        check("hit c_addr", c_addr, 16'h1238);
        check("hit rdata", rdata, 16'hBEEF);
        check("hit req_cnt", req_cnt, 1);
        check("hit hit_cnt", hit_cnt, 1);

        // Store miss, done after 12 BUSY cycles.
        run_req(1'b0, 1'b1, 16'h0800, 16'h1234, 12, 1'b0, 16'h5555, 0, 14, s_n, a_n, f_a, v_at);
        check("store write cycles", a_n, 12);
        check("store valid cycle", v_at, 13);
        check("store c_data_in", c_data_in, 16'h1234);
        check("store rdata kept", rdata, 16'hBEEF);
        check("store req_cnt", req_cnt, 2);
        check("store hit_cnt", hit_cnt, 1);

        // Cache error in the done cycle: flagged, request still completes.
        run_req(1'b1, 1'b0, 16'h0042, 16'h0, 3, 1'b1, 16'h7777, 3, 5, s_n, a_n, f_a, v_at);
        check("cerr err", err, 1'b1);
        check("cerr valid cycle", v_at, 4);
        check("cerr rdata", rdata, 16'h7777);
        check("cerr req_cnt", req_cnt, 3);

        // done while idle must be ignored.
        do_reset();
        c_done = 1'b1; c_hit = 1'b1; c_data_out = 16'h4321;
        repeat (2) step();
        c_done = 1'b0; c_hit = 1'b0;
        check("idle done req_cnt", req_cnt, 0);
        check("idle done rdata", rdata, 16'h0);

        // Illegal read+write request.
        run_req(1'b1, 1'b1, 16'h1111, 16'h2222, 0, 1'b0, 16'h0, 0, 3, s_n, a_n, f_a, v_at);
        check("illegal strobes", a_n, 0);
        check("illegal stall cycles", s_n, 1);
        check("illegal err", err, 1'b1);
        check("illegal valid", v_at, -1);
        check("illegal req_cnt", req_cnt, 0);

        // Watchdog timeout on a load.
        do_reset();
        run_req(1'b1, 1'b0, 16'h0300, 16'h0, 0, 1'b0, 16'h0, 0, TB_TIMEOUT + 3, s_n, a_n, f_a, v_at);
        check("timeout read cycles", a_n, TB_TIMEOUT);
        check("timeout stall cycles", s_n, TB_TIMEOUT + 1);
        check("timeout valid", v_at, -1);
        check("timeout err", err, 1'b1);
        check("timeout req_cnt", req_cnt, 0);

        // done in the last BUSY cycle before the watchdog fires wins.
        do_reset();
        run_req(1'b1, 1'b0, 16'h0310, 16'h0, TB_TIMEOUT, 1'b0, 16'h0A0A, 0, TB_TIMEOUT + 2, s_n, a_n, f_a, v_at);
        check("edge valid cycle", v_at, TB_TIMEOUT + 1);
        check("edge err", err, 1'b0);
        check("edge rdata", rdata, 16'h0A0A);
        check("edge req_cnt", req_cnt, 1);

        // Asynchronous reset in the middle of a store.
        p_write = 1'b1; p_addr = 16'h0900; p_wdata = 16'hAAAA;
        step();
        p_write = 1'b0;
        repeat (2) step();
        check("midrst c_write before", c_write, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst c_write", c_write, 1'b0);
        check("midrst c_addr", c_addr, 16'h0);
        check("midrst stall", stall, 1'b0);
        check("midrst req_cnt", req_cnt, 0);
        #3 rst = 1'b0;
        step();
        run_req(1'b0, 1'b0, 16'h0, 16'h0, 0, 1'b0, 16'h0, 0, 4, s_n, a_n, f_a, v_at);
        check("midrst no valid", v_at, -1);
        check("midrst no strobes", a_n, 0);

        // Back-to-back load hits saturate both counters.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            run_req(1'b1, 1'b0, 16'(i * 16), 16'h0, 2, 1'b1, 16'(i * 16'h1111), 0, 4, s_n, a_n, f_a, v_at);
            check("b2b first strobe", f_a, 1);
            check("b2b valid cycle", v_at, 3);
        end
        check("sat req_cnt", req_cnt, 3);
        check("sat hit_cnt", hit_cnt, 3);
        check("sat rdata", rdata, 16'h5555);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
